// File: rtl/romsel_reg_pkg.sv
// Shared definitions for the ROM select register: FSM encoding and port decode constants.
package romsel_reg_pkg;

    // Write qualification FSM: a write must be seen on two consecutive edges to latch.
    typedef enum logic [1:0] {
        StIdle,
        StQual,
        StDone
    } romsel_state_e;

    // Address bit that must be low for the &DFxx ROM select port.
    localparam int unsigned PortSelBit = 13;

    // Number of upper ROM slots covered by present_i.
    localparam int unsigned NumSlots = 16;

endpackage

// File: rtl/romsel_reg_if.sv
// Z80 I/O write bus plus ROM-select results, bundled for the register and its surroundings.
interface romsel_reg_if;

    logic [15:0] a;
    logic [7:0]  d;
    logic        iorq_n;
    logic        wr_n;
    logic        m1_n;
    logic [15:0] present;
    logic [7:0]  rom_num;
    logic [3:0]  sel;
    logic        changed;

    // CPU / board side: drives the bus and slot population, observes the selection.
    modport master (
        output a, d, iorq_n, wr_n, m1_n, present,
        input  rom_num, sel, changed
    );

    // Register side: observes the bus, produces the selection.
    modport slave (
        input  a, d, iorq_n, wr_n, m1_n, present,
        output rom_num, sel, changed
    );

endinterface

// File: rtl/romsel_reg.sv
// Upper ROM select register: qualifies Z80 writes to port &DFxx, latches the ROM number
// once per IORQ assertion and maps it onto a populated slot selector.
module romsel_reg
    import romsel_reg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] a_i,
    input  logic [7:0]  d_i,
    input  logic        iorq_n_i,
    input  logic        wr_n_i,
    input  logic        m1_n_i,
    input  logic [15:0] present_i,
    output logic [7:0]  rom_num_o,
    output logic [3:0]  sel_o,
    output logic        changed_o
);

    romsel_state_e state_q, state_d;
    logic [7:0]    rom_num_q, rom_num_d;
    logic [3:0]    sel_q, sel_d;
    logic          changed_q, changed_d;
    logic          wc;
    logic          slot_ok;

    // Only bit 13 of the address takes part in the decode.
    logic unused_a;
    assign unused_a = ^(a_i & ~(16'd1 << PortSelBit));

    // Port write decode; interrupt acknowledge (M1 low) never qualifies.
    assign wc = !iorq_n_i && !wr_n_i && m1_n_i && !a_i[PortSelBit];

    // A ROM number maps to its own slot only if it is in range and populated.
    assign slot_ok = (32'(rom_num_q) < NumSlots) && present_i[rom_num_q[3:0]];

    // Next-state: write qualification, latch, change pulse and slot mapping.
    always_comb begin
        state_d   = state_q;
        rom_num_d = rom_num_q;
        changed_d = 1'b0;
        sel_d     = slot_ok ? rom_num_q[3:0] : 4'd0;

        unique case (state_q)
            StIdle: begin
                if (wc) begin
                    state_d = StQual;
                end
            end
            StQual: begin
                if (wc) begin
                    state_d   = StDone;
                    rom_num_d = d_i;
                    changed_d = (d_i != rom_num_q);
                end else begin
                    // Single-cycle strobe: treat as a glitch.
                    state_d = StIdle;
                end
            end
            StDone: begin
                // Hold until IORQ releases so a long write latches only once.
                if (iorq_n_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            rom_num_q <= 8'd0;
            sel_q     <= 4'd0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rom_num_q <= rom_num_d;
            sel_q     <= sel_d;
            changed_q <= changed_d;
        end
    end

    assign rom_num_o = rom_num_q;
    assign sel_o     = sel_q;
    assign changed_o = changed_q;

endmodule

// File: tb/tb_romsel_reg.sv
// Scoreboard bench for romsel_reg: directed scenarios then randomized bus traffic,
// checked cycle by cycle against a behavioural model of the ROM select rules.
module tb_romsel_reg;

    typedef struct packed {
        logic [7:0] rom;
        logic [3:0] sel;
        logic       chg;
    } obs_t;

    logic clk;
    logic rst;
    romsel_reg_if bus ();

    romsel_reg dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .a_i       (bus.a),
        .d_i       (bus.d),
        .iorq_n_i  (bus.iorq_n),
        .wr_n_i    (bus.wr_n),
        .m1_n_i    (bus.m1_n),
        .present_i (bus.present),
        .rom_num_o (bus.rom_num),
        .sel_o     (bus.sel),
        .changed_o (bus.changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pushed = 0;

    // Reference model: a write is accepted on its second consecutive qualifying sample,
    // and only once until IORQ is seen released.
    logic [7:0] m_rom;
    logic [3:0] m_sel;
    logic       m_chg;
    logic       m_locked;
    logic       m_seen;

    task automatic model_step(input logic r, input logic [15:0] a, input logic [7:0] d,
                              input logic iorq_n, input logic wr_n, input logic m1_n,
                              input logic [15:0] present);
        logic wc;
        wc = (iorq_n == 1'b0) && (wr_n == 1'b0) && (m1_n == 1'b1) && (a[13] == 1'b0);
        if (r) begin
            m_rom = 8'd0; m_sel = 4'd0; m_chg = 1'b0; m_locked = 1'b0; m_seen = 1'b0;
        end else begin
            m_sel = (m_rom < 8'd16 && present[m_rom]) ? m_rom[3:0] : 4'd0;
            m_chg = 1'b0;
            if (m_locked) begin
                if (iorq_n) m_locked = 1'b0;
                m_seen = 1'b0;
            end else if (wc) begin
                if (m_seen) begin
                    m_chg    = (d != m_rom);
                    m_rom    = d;
                    m_locked = 1'b1;
                    m_seen   = 1'b0;
                end else begin
                    m_seen = 1'b1;
                end
            end else begin
                m_seen = 1'b0;
            end
        end
    endtask

    // One bus cycle: drive on the falling edge, predict the state after the next rising edge.
    task automatic drive(input logic r, input logic [15:0] a, input logic [7:0] d,
                         input logic iorq_n, input logic wr_n, input logic m1_n,
                         input logic [15:0] present);
        @(negedge clk);
        rst = r; bus.a = a; bus.d = d; bus.iorq_n = iorq_n; bus.wr_n = wr_n;
        bus.m1_n = m1_n; bus.present = present;
        model_step(r, a, d, iorq_n, wr_n, m1_n, present);
        exp_q.push_back('{rom: m_rom, sel: m_sel, chg: m_chg});
        n_pushed++;
    endtask

    task automatic idle(input int n, input logic [15:0] present);
        for (int i = 0; i < n; i++) drive(1'b0, 16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b1, present);
    endtask

    // I/O write held for n cycles, optionally as interrupt acknowledge, then bus released.
    task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int n,
                            input logic m1_n, input logic [15:0] present);
        for (int i = 0; i < n; i++) drive(1'b0, a, d, 1'b0, 1'b0, m1_n, present);
        idle(2, present);
    endtask

    // Monitor: compares every cycle's outputs against the oldest prediction.
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g = '{rom: bus.rom_num, sel: bus.sel, chg: bus.changed};
                n_checks++;
                if (g === e) n_pass++;
                else $display("FAIL outputs @%0t: got rom=%h sel=%0d chg=%b, want rom=%h sel=%0d chg=%b",
                              $time, g.rom, g.sel, g.chg, e.rom, e.sel, e.chg);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", n_checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] pres;
        logic [15:0] addr;
        logic [7:0]  data;
        int          len;

        rst = 1'b1; bus.a = 16'hFFFF; bus.d = 8'h00; bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        bus.m1_n = 1'b1; bus.present = 16'h0000;
        m_rom = 8'd0; m_sel = 4'd0; m_chg = 1'b0; m_locked = 1'b0; m_seen = 1'b0;

        // Reset state.
        drive(1'b1, 16'hFFFF, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0021);
        drive(1'b1, 16'hFFFF, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0021);
        idle(2, 16'h0021);

        // Slot 5 populated: latch at E1, single pulse, sel 5 at E2.
        io_write(16'hDF00, 8'h05, 3, 1'b1, 16'h0021);
        // Same value again: no pulse.
        io_write(16'hDF00, 8'h05, 3, 1'b1, 16'h0021);
        // Clearing present bit 5 falls back to BASIC without a pulse.
        idle(3, 16'h0001);
        // Unpopulated slot and out-of-range number.
        io_write(16'hDF00, 8'h07, 2, 1'b1, 16'h0001);
        io_write(16'hDF00, 8'h20, 4, 1'b1, 16'hFFFF);
        // Single-cycle glitch.
        io_write(16'hDF00, 8'h03, 1, 1'b1, 16'hFFFF);
        // Interrupt acknowledge and a write to &FF00 are ignored.
        io_write(16'hDF00, 8'h03, 3, 1'b0, 16'hFFFF);
        io_write(16'hFF00, 8'h03, 3, 1'b1, 16'hFFFF);
        // Reset in QUAL: pending write dropped.
        io_write(16'hDF00, 8'h02, 1, 1'b1, 16'hFFFF);
        drive(1'b0, 16'hDF00, 8'h09, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        drive(1'b1, 16'hDF00, 8'h09, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        idle(2, 16'hFFFF);
        // Write still asserted when reset releases is qualified afresh.
        drive(1'b0, 16'hDF00, 8'h04, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        drive(1'b1, 16'hDF00, 8'h04, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        io_write(16'hDF00, 8'h04, 3, 1'b1, 16'hFFFF);

        // Randomized traffic.
        pres = 16'h0021;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 7) == 0) pres = 16'($urandom);
            addr = 16'($urandom);
            if ($urandom_range(0, 3) != 0) addr[13] = 1'b0;
            data = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom);
            len  = $urandom_range(1, 4);
            for (int c = 0; c < len; c++) begin
                drive(($urandom_range(0, 49) == 0), addr, data, 1'b0,
                      ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) != 0), pres);
            end
            idle($urandom_range(0, 2), pres);
        end
        idle(2, pres);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0 && n_checks == n_pushed + 1) n_pass++;
        else $display("FAIL drain: got %0d compared with %0d pending, want %0d compared with 0 pending",
                      n_checks - 1, exp_q.size(), n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/romsel_reg.md
ROMSEL_REG -- requirements
Module: romsel_reg

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single system clock; every register updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port a_i, input, 16 bits: Z80 address bus, synchronous to clk_i.
REQ-004 SHALL have port d_i, input, 8 bits: Z80 data bus, carrying the CPU write data.
REQ-005 SHALL have port iorq_n_i, input, 1 bit: Z80 IORQ, active low.
REQ-006 SHALL have port wr_n_i, input, 1 bit: Z80 WR, active low.
REQ-007 SHALL have port m1_n_i, input, 1 bit: Z80 M1, active low; IORQ with M1 low is an interrupt acknowledge.
REQ-008 SHALL have port present_i, input, 16 bits: bit n = 1 when upper ROM slot n is populated.
REQ-009 SHALL have port rom_num_o, output, 8 bits: last ROM number written by the CPU.
REQ-010 SHALL have port sel_o, output, 4 bits: slot selector, driving the ROM data arbiter selector input.
REQ-011 SHALL have port changed_o, output, 1 bit: one-cycle pulse when rom_num_o takes a new, different value.

Function
REQ-012 SHALL define the write condition wc = !iorq_n_i & !wr_n_i & m1_n_i & !a_i[13] (port &DFxx decode); all other address bits are don't-care.
REQ-013 SHALL implement FSM states IDLE, QUAL and DONE.
REQ-014 FSM transitions SHALL be:
  - IDLE -> QUAL when wc = 1.
  - QUAL -> DONE when wc = 1, latching rom_num_o <= d_i on that edge.
  - QUAL -> IDLE when wc = 0 (glitch rejected, no latch).
  - DONE -> IDLE when iorq_n_i = 1; otherwise remain in DONE.
REQ-015 SHALL latch at most one value per IORQ assertion, however long wc stays true.
REQ-016 If wc is first sampled true at edge E0 and still true at E1, rom_num_o SHALL change at E1.
REQ-017 changed_o SHALL be 1 for the cycle after E1 only when the latched value differs from the previous rom_num_o; otherwise 0.
REQ-018 sel_o SHALL be registered every clock as:
  - rom_num_o[3:0] when rom_num_o < 16 and present_i[rom_num_o] = 1;
  - 4'd0 otherwise (BASIC fallback).
REQ-019 sel_o SHALL follow rom_num_o or present_i changes with exactly one cycle of latency (valid at E2 for a write latched at E1).
REQ-020 SHALL ignore wc when m1_n_i = 0 (interrupt acknowledge) and when a_i[13] = 1.
REQ-021 If iorq_n_i deasserts and a new wc appears on the same edge that DONE exits, the FSM SHALL go to IDLE and requalify on the following edges.
REQ-022 A change of present_i SHALL NOT alter rom_num_o and SHALL NOT pulse changed_o.

Reset
REQ-023 While rst_i = 1 at a clock edge: FSM -> IDLE, rom_num_o = 8'd0, sel_o = 4'd0, changed_o = 0.
REQ-024 Reset SHALL take priority over any write in progress; a write interrupted mid-QUAL SHALL NOT be latched.
REQ-025 After reset deasserts, a wc already asserted SHALL be qualified from IDLE as a new write.

Structure
REQ-026 The FSM state encoding and the port decode constants (address bit 13, the 16-slot count) SHALL live in the shared cpc package.
REQ-027 No sub-module is required; the wc decode and sel_o mapping SHALL be local logic.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  - Write &05 to &DF00 over 3 cycles of wc, present_i = 16'h0021: rom_num_o = 8'h05 at E1; changed_o pulses once; sel_o = 4'd5 at E2.
  - Write &07 to &DF00, present_i = 16'h0001: rom_num_o = 8'h07; sel_o = 4'd0.
  - Write &20 to &DF00: rom_num_o = 8'h20; sel_o = 4'd0.
  - Single-cycle wc glitch carrying &03: no latch; changed_o stays 0.
  - Write &05 to &DF00 twice in a row: second write leaves rom_num_o unchanged and produces no changed_o pulse.
  - IORQ with M1 low, or a write to &FF00: rom_num_o unchanged.
  - rst_i asserted in QUAL: all outputs 0; the pending write is not latched.
  - present_i bit 5 cleared while rom_num_o = 5: sel_o = 4'd0 one cycle later; changed_o stays 0.
